// File: rtl/game_params_pkg.sv
// Shared game geometry and timing constants used by the engine and the enemy shots.
// Also holds the fleet-relative spawn position helpers.
package game_params;

    localparam int COLUNAS   = 13;
    localparam int SPACING_X = 40;
    localparam int SPACING_Y = 32;
    localparam int OFF_X     = 16;
    localparam int OFF_Y     = 24;
    localparam int SCREEN_H  = 480;
    localparam int PLAYER_Y  = 440;
    localparam int PLAYER_W  = 32;
    localparam int LIVES     = 3;

    localparam logic [1:0] ST_RUNNING = 2'd1;

    typedef enum logic {
        TICK_HOLD,
        TICK_RUN
    } tick_mode_t;

    // All terms are folded to 10 bits so screen coordinates wrap consistently
    function automatic logic [9:0] spawn_x(
        input logic [9:0] fx,
        input logic [5:0] sx,
        input logic [5:0] row,
        input int         cols,
        input int         spacing,
        input int         off
    );
        logic [9:0] col;
        col = 10'(sx) - 10'(row * cols);
        return fx + 10'(col * spacing) + 10'(off);
    endfunction

    function automatic logic [9:0] spawn_y(
        input logic [9:0] fy,
        input logic [5:0] row,
        input int         spacing,
        input int         off
    );
        return fy + 10'(row * spacing) + 10'(off);
    endfunction

endpackage

// File: rtl/enemy_shots_shot_slot.sv
// One enemy bullet: valid flag, position, downward movement and player hit test.
// A hit wins over movement; spawning is only ever requested into an idle slot.
module shot_slot
    import game_params::*;
#(
    parameter int STEP_Y   = 4,
    parameter int SCREEN_H = game_params::SCREEN_H,
    parameter int PLAYER_Y = game_params::PLAYER_Y,
    parameter int PLAYER_W = game_params::PLAYER_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_restart,
    input  logic       i_run,
    input  logic       i_tick,
    input  logic       i_spawn,
    input  logic [9:0] i_spawn_x,
    input  logic [9:0] i_spawn_y,
    input  logic [9:0] i_player_x,
    output logic       o_active,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic       o_hit
);

    logic        r_active;
    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic [10:0] w_player_end;
    logic [10:0] w_next_y;

    // Widened so a player near the right edge does not wrap its hitbox
    assign w_player_end = {1'b0, i_player_x} + 11'(PLAYER_W);
    assign w_next_y     = {1'b0, r_y} + 11'(STEP_Y);

    assign o_hit = r_active
                 && (r_y >= 10'(PLAYER_Y))
                 && (r_x >= i_player_x)
                 && ({1'b0, r_x} < w_player_end);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
        end else if (i_restart) begin
            r_active <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
        end else if (i_run) begin
            if (o_hit) begin
                r_active <= 1'b0;
            end else if (i_spawn) begin
                r_active <= 1'b1;
                r_x      <= i_spawn_x;
                r_y      <= i_spawn_y;
            end else if (i_tick && r_active) begin
                if (w_next_y >= 11'(SCREEN_H)) begin
                    r_active <= 1'b0;
                end else begin
                    r_y <= w_next_y[9:0];
                end
            end
        end
    end

    assign o_active = r_active;
    assign o_x      = r_x;
    assign o_y      = r_y;

endmodule

// File: rtl/enemy_shots.sv
// Enemy bullet pool: spawns a shot when the engine picks a new shooter,
// moves shots on a slow tick, and charges at most one life per cycle of hits.
module enemy_shots
    import game_params::*;
#(
    parameter int N_SLOTS     = 4,
    parameter int COLUNAS     = game_params::COLUNAS,
    parameter int TICK_CYCLES = 500000,
    parameter int STEP_Y      = 4,
    parameter int SPACING_X   = game_params::SPACING_X,
    parameter int SPACING_Y   = game_params::SPACING_Y,
    parameter int OFF_X       = game_params::OFF_X,
    parameter int OFF_Y       = game_params::OFF_Y,
    parameter int SCREEN_H    = game_params::SCREEN_H,
    parameter int PLAYER_Y    = game_params::PLAYER_Y,
    parameter int PLAYER_W    = game_params::PLAYER_W,
    parameter int LIVES       = game_params::LIVES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  restart,
    input  logic [5:0]            shooter_x,
    input  logic [5:0]            shooter_row,
    input  logic [1:0]            estado_jogo,
    input  logic [9:0]            fleet_x,
    input  logic [9:0]            fleet_y,
    input  logic [9:0]            player_x,
    output logic [N_SLOTS-1:0]    bullet_active,
    output logic [10*N_SLOTS-1:0] bullet_x,
    output logic [10*N_SLOTS-1:0] bullet_y,
    output logic [1:0]            lives,
    output logic                  jogador_vivo
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    logic [5:0]         r_prev_id;
    logic [CW-1:0]      r_tick_cnt;
    logic [1:0]         r_lives;
    tick_mode_t         w_tmode;
    logic               w_run;
    logic               w_tick;
    logic               w_spawn_req;
    logic               w_found;
    logic [N_SLOTS-1:0] w_free_sel;
    logic [N_SLOTS-1:0] w_hit;
    logic [9:0]         w_spawn_x;
    logic [9:0]         w_spawn_y;

    assign w_run       = (estado_jogo == ST_RUNNING);
    assign w_tmode     = w_run ? TICK_RUN : TICK_HOLD;
    assign w_tick      = (w_tmode == TICK_RUN)
                       && (r_tick_cnt == CW'(TICK_CYCLES - 1));
    assign w_spawn_req = w_run && (shooter_x != r_prev_id);

    assign w_spawn_x = spawn_x(fleet_x, shooter_x, shooter_row,
                               COLUNAS, SPACING_X, OFF_X);
    assign w_spawn_y = spawn_y(fleet_y, shooter_row, SPACING_Y, OFF_Y);

    // Lowest-index idle slot; a slot freed this cycle is not reused until next
    always_comb begin
        w_free_sel = '0;
        w_found    = 1'b0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (!bullet_active[i] && !w_found) begin
                w_free_sel[i] = 1'b1;
                w_found       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (restart) begin
            r_tick_cnt <= '0;
        end else begin
            unique case (w_tmode)
                TICK_RUN:  r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
                TICK_HOLD: r_tick_cnt <= r_tick_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_id <= '0;
            r_lives   <= 2'(LIVES);
        end else if (restart) begin
            r_prev_id <= '0;
            r_lives   <= 2'(LIVES);
        end else begin
            r_prev_id <= shooter_x;
            if (w_run && (|w_hit) && (r_lives != 2'd0)) begin
                r_lives <= r_lives - 2'd1;
            end
        end
    end

    for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
        shot_slot #(
            .STEP_Y   (STEP_Y),
            .SCREEN_H (SCREEN_H),
            .PLAYER_Y (PLAYER_Y),
            .PLAYER_W (PLAYER_W)
        ) u_slot (
            .clk        (clk),
            .reset      (reset),
            .i_restart  (restart),
            .i_run      (w_run),
            .i_tick     (w_tick),
            .i_spawn    (w_spawn_req && w_free_sel[i]),
            .i_spawn_x  (w_spawn_x),
            .i_spawn_y  (w_spawn_y),
            .i_player_x (player_x),
            .o_active   (bullet_active[i]),
            .o_x        (bullet_x[10*i +: 10]),
            .o_y        (bullet_y[10*i +: 10]),
            .o_hit      (w_hit[i])
        );
    end

    assign lives        = r_lives;
    assign jogador_vivo = (r_lives != 2'd0);

endmodule

// File: tb/tb_enemy_shots.sv
// Self-checking bench for enemy_shots: spawn table, directed corner sequences,
// and randomized traffic against a slot-array reference model.
module tb_enemy_shots;

    localparam int T = 4;

    logic        clk;
    logic        reset;
    logic        restart;
    logic [5:0]  shooter_x;
    logic [5:0]  shooter_row;
    logic [1:0]  estado_jogo;
    logic [9:0]  fleet_x;
    logic [9:0]  fleet_y;
    logic [9:0]  player_x;
    logic [3:0]  bullet_active;
    logic [39:0] bullet_x;
    logic [39:0] bullet_y;
    logic [1:0]  lives;
    logic        jogador_vivo;

    int n_chk;
    int n_pass;

    int m_x[4];
    int m_y[4];
    bit m_act[4];
    int m_lives;
    int m_cnt;
    int m_prev;

    typedef struct {
        int fx;
        int fy;
        int sx;
        int row;
        int ex;
        int ey;
    } spawn_vec_t;

    spawn_vec_t vecs[6];

    enemy_shots #(
        .N_SLOTS     (4),
        .TICK_CYCLES (T)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .restart       (restart),
        .shooter_x     (shooter_x),
        .shooter_row   (shooter_row),
        .estado_jogo   (estado_jogo),
        .fleet_x       (fleet_x),
        .fleet_y       (fleet_y),
        .player_x      (player_x),
        .bullet_active (bullet_active),
        .bullet_x      (bullet_x),
        .bullet_y      (bullet_y),
        .lives         (lives),
        .jogador_vivo  (jogador_vivo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_x[i] = 0;
            m_y[i] = 0;
            m_act[i] = 0;
        end
        m_lives = 3;
        m_cnt = 0;
        m_prev = 0;
    endtask

    task automatic model_step();
        bit req;
        bit tk;
        bit any_hit;
        bit old_act[4];
        int s;
        int col;
        int px;
        if (restart) begin
            model_reset();
            return;
        end
        req = (int'(shooter_x) != m_prev);
        m_prev = int'(shooter_x);
        if (estado_jogo != 2'd1) return;
        tk = (m_cnt == T - 1);
        m_cnt = tk ? 0 : m_cnt + 1;
        old_act = m_act;
        any_hit = 0;
        px = int'(player_x);
        for (int i = 0; i < 4; i++) begin
            if (m_act[i] && m_y[i] >= 440 && px <= m_x[i] && m_x[i] < px + 32) begin
                m_act[i] = 0;
                any_hit = 1;
            end else if (m_act[i] && tk) begin
                if (m_y[i] + 4 >= 480) m_act[i] = 0;
                else m_y[i] = m_y[i] + 4;
            end
        end
        if (req) begin
            s = -1;
            for (int i = 0; i < 4; i++)
                if (!old_act[i] && s < 0) s = i;
            if (s >= 0) begin
                col = int'(shooter_x) - int'(shooter_row) * 13;
                m_x[s] = (int'(fleet_x) + col * 40 + 16) & 1023;
                m_y[s] = (int'(fleet_y) + int'(shooter_row) * 32 + 24) & 1023;
                m_act[s] = 1;
            end
        end
        if (any_hit && m_lives > 0) m_lives--;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_in(input int fx, input int fy, input int sx,
                          input int row, input int px);
        fleet_x = 10'(fx);
        fleet_y = 10'(fy);
        shooter_x = 6'(sx);
        shooter_row = 6'(row);
        player_x = 10'(px);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    task automatic cmp_model();
        logic [3:0] ea;
        for (int i = 0; i < 4; i++) ea[i] = m_act[i];
        check("rnd_active", int'(bullet_active), int'(ea));
        check("rnd_lives", int'(lives), m_lives);
        check("rnd_vivo", int'(jogador_vivo), int'(m_lives != 0));
        for (int i = 0; i < 4; i++) begin
            if (m_act[i]) begin
                check("rnd_x", int'(bullet_x[10*i +: 10]), m_x[i]);
                check("rnd_y", int'(bullet_y[10*i +: 10]), m_y[i]);
            end
        end
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        reset = 1'b1;
        restart = 1'b0;
        estado_jogo = 2'd1;
        set_in(0, 0, 0, 0, 900);
        model_reset();
        vecs[0] = '{100, 50, 15, 1, 196, 106};
        vecs[1] = '{0, 0, 1, 0, 56, 24};
        vecs[2] = '{200, 100, 12, 0, 696, 124};
        vecs[3] = '{900, 450, 40, 3, 956, 570};
        vecs[4] = '{1000, 1000, 14, 1, 32, 32};
        vecs[5] = '{100, 50, 2, 1, 700, 106};

        repeat (2) @(posedge clk);
        #1;
        check("rst_active", int'(bullet_active), 0);
        check("rst_x", int'(bullet_x != 0), 0);
        check("rst_y", int'(bullet_y != 0), 0);
        check("rst_lives", int'(lives), 3);
        check("rst_vivo", int'(jogador_vivo), 1);
        reset = 1'b0;

        // Spawn position table
        for (int v = 0; v < 6; v++) begin
            shooter_x = 6'd0;
            do_restart();
            set_in(vecs[v].fx, vecs[v].fy, vecs[v].sx, vecs[v].row, 900);
            step();
            check("spawn_active", int'(bullet_active), 1);
            check("spawn_x", int'(bullet_x[9:0]), vecs[v].ex);
            check("spawn_y", int'(bullet_y[9:0]), vecs[v].ey);
        end

        // Fall and expiry at the bottom edge
        set_in(0, 448, 0, 0, 900);
        do_restart();
        shooter_x = 6'd1;
        step();
        check("fall_y0", int'(bullet_y[9:0]), 472);
        step();
        step();
        check("fall_hold", int'(bullet_y[9:0]), 472);
        step();
        check("fall_y1", int'(bullet_y[9:0]), 476);
        repeat (4) step();
        check("fall_expire", int'(bullet_active), 0);
        check("fall_lives", int'(lives), 3);

        // Pool overflow; slot 3 spawns on the tick edge and must not move
        set_in(0, 0, 0, 0, 900);
        do_restart();
        for (int k = 1; k <= 5; k++) begin
            shooter_x = 6'(k);
            step();
        end
        check("pool_full", int'(bullet_active), 15);
        check("pool_s3_x", int'(bullet_x[39:30]), 176);
        check("pool_s3_y", int'(bullet_y[39:30]), 24);
        check("pool_s0_y", int'(bullet_y[9:0]), 28);

        // Two slots hit on the same cycle cost one life
        set_in(0, 0, 0, 0, 900);
        do_restart();
        set_in(0, 416, 1, 0, 900);
        step();
        set_in(4, 384, 14, 1, 900);
        step();
        player_x = 10'd50;
        step();
        check("dbl_active", int'(bullet_active), 0);
        check("dbl_lives", int'(lives), 2);
        check("dbl_vivo", int'(jogador_vivo), 1);

        // Remaining hits down to zero, then one more to test saturation
        for (int h = 0; h < 3; h++) begin
            if (h % 2 == 0) set_in(0, 416, 1, 0, 900);
            else set_in(4, 384, 14, 1, 900);
            step();
            player_x = 10'd50;
            step();
        end
        check("death_lives", int'(lives), 0);
        check("death_vivo", int'(jogador_vivo), 0);
        check("death_active", int'(bullet_active), 0);

        // Freeze while not running; prev_id keeps tracking
        set_in(0, 0, 14, 1, 900);
        step();
        estado_jogo = 2'd3;
        shooter_x = 6'd5;
        repeat (10) step();
        check("frz_active", int'(bullet_active), 1);
        check("frz_x", int'(bullet_x[9:0]), 56);
        check("frz_y", int'(bullet_y[9:0]), 56);
        estado_jogo = 2'd1;
        step();
        check("frz_noresp", int'(bullet_active), 1);

        // Async reset between edges with three slots in flight
        shooter_x = 6'd1;
        step();
        shooter_x = 6'd2;
        step();
        check("mid_pre", int'(bullet_active), 7);
        #1 reset = 1'b1;
        #1;
        check("mid_active", int'(bullet_active), 0);
        check("mid_lives", int'(lives), 3);
        check("mid_vivo", int'(jogador_vivo), 1);
        check("mid_xy", int'((bullet_x | bullet_y) != 0), 0);
        model_reset();
        #1 reset = 1'b0;

        // Randomized traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            restart = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 9) == 0) estado_jogo = 2'($urandom_range(0, 3));
            else estado_jogo = 2'd1;
            if ($urandom_range(0, 3) == 0) begin
                shooter_x = 6'($urandom_range(0, 63));
                shooter_row = 6'($urandom_range(0, 4));
            end
            fleet_x = 10'($urandom_range(0, 120));
            fleet_y = 10'($urandom_range(360, 460));
            player_x = 10'($urandom_range(0, 200));
            step();
            cmp_model();
        end
        restart = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
